md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline.
//  Sits in EX beside the ALU and accepts mult/multu/div/divu/mthi/mtlo from EX.
//  Provides a stall request to the hazard logic while an operation is in flight.
//  Generalises the single-cycle datapath: configurable width, configurable latencies,
//  explicit busy handshake and defined divide corner cases.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width in bits (>=8)
//  MULT_CYCLES  5   cycles busy is high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles busy is high for div/divu (>=1)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      asynchronous, active-low (0 = reset)
//  start      in   1      request, sampled on rising edge
//  op         in   3      0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//  a          in   WIDTH  rs operand / dividend / mthi-mtlo data
//  b          in   WIDTH  rt operand / divisor
//  busy       out  1      operation in flight
//  stall_req  out  1      comb: busy | (start & op<=3)
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): busy=0, hi=0, lo=0, counter=0, stored result cleared.
//    An in-flight operation is abandoned; HI/LO stay 0 after release.
//  - States: IDLE, RUN. In IDLE, an edge with start=1 and op 0-3 latches a, b, and op,
//    loads the counter with N (MULT_CYCLES or DIV_CYCLES), and enters RUN with busy=1.
//  - RUN: the counter decrements each edge. On the edge where it reaches 0, hi/lo update
//    atomically, busy=0, and the unit returns to IDLE. busy is high for exactly N cycles.
//    hi/lo are not visible before that edge.
//  - start is ignored while busy=1 for every op, including mthi/mtlo. Issue logic must stall.
//  - mthi/mtlo in IDLE: hi<=a or lo<=a on the sampled edge. Single cycle, busy stays 0.
//  - A start on the same edge that busy falls is ignored, because the unit is still in RUN
//    on that edge. The next start is accepted one cycle later.
//  - op 6-7 with start: no state change.
//  - mult:  {hi,lo} = signed a * signed b, 2*WIDTH-bit product.
//  - multu: {hi,lo} = unsigned a * unsigned b.
//  - div:   signed, truncate toward zero; lo = quotient, hi = remainder (sign of dividend).
//  - divu:  unsigned; lo = quotient, hi = remainder.
//  - Divide by zero (both div and divu): lo = all ones, hi = a.
//  - Signed overflow (a = -2^(WIDTH-1), b = -1): lo = a, hi = 0.
//  - The result may be computed combinationally from the latched operands or iteratively.
//    Either way, only the committed value at the end of RUN is observable.
//  - stall_req is purely combinational and has no dependence on reset other than through busy.
// TESTING
//  1. reset=0 mid-run (mult started, 2 cycles in) -> busy=0 immediately, hi=lo=0,
//     no commit after release.
//  2. mult a=-3 (0xFFFFFFFD), b=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF,
//     lo=0xFFFFFFEB.
//  3. multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  4. div a=-7, b=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     divu a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
//  5. div a=0x80000000, b=-1 -> lo=0x80000000, hi=0. stall_req=1 in start cycle and all busy cycles.
//  6. mthi 0x1234 while busy -> ignored, hi = op result. mtlo 0xABCD in IDLE -> lo=0xABCD
//     next edge, busy=0. start on commit edge ignored; repeat with MULT_CYCLES=1, DIV_CYCLES=3.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers and stall.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_mult_n = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_n  = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(1);
  localparam logic [2:0] c_op_divu = 3'd3;
  localparam logic [2:0] c_op_mthi = 3'd4;
  localparam logic [2:0] c_op_mtlo = 3'd5;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_a, r_b, r_hi, r_lo;
  logic [1:0]           r_op;
  logic                 w_accept, w_commit, w_mthi, w_mtlo;
  logic [2*WIDTH-1:0]   w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_quo_mag, w_rem_mag;
  logic [WIDTH-1:0]     w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic [WIDTH-1:0]     w_hi_res, w_lo_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (op <= c_op_divu)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_last) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mthi    = (r_state == ST_IDLE) && start && (op == c_op_mthi);
  assign w_mtlo    = (r_state == ST_IDLE) && start && (op == c_op_mtlo);
  assign busy      = (r_state == ST_RUN);
  assign stall_req = busy | (start & (op <= c_op_divu));

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign w_a_sx   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_sx   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed divide via magnitudes; -2^(W-1)/-1 falls out as quotient a, remainder 0.
  assign w_a_neg   = r_a[WIDTH-1];
  assign w_b_neg   = r_b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -r_b : r_b;
  assign w_quo_mag = w_a_mag / w_b_mag;
  assign w_rem_mag = w_a_mag % w_b_mag;
  assign w_quo_s   = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
  assign w_rem_s   = w_a_neg ? -w_rem_mag : w_rem_mag;
  assign w_quo_u   = r_a / r_b;
  assign w_rem_u   = r_a % r_b;

  always_comb begin
    w_hi_res = '0;
    w_lo_res = '0;
    case (r_op)
      2'd0: {w_hi_res, w_lo_res} = w_prod_s;
      2'd1: {w_hi_res, w_lo_res} = w_prod_u;
      2'd2: begin
        if (r_b == '0) begin
          w_hi_res = r_a;
          w_lo_res = '1;
        end else begin
          w_hi_res = w_rem_s;
          w_lo_res = w_quo_s;
        end
      end
      default: begin
        if (r_b == '0) begin
          w_hi_res = r_a;
          w_lo_res = '1;
        end else begin
          w_hi_res = w_rem_u;
          w_lo_res = w_quo_u;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= op[1:0];
        r_cnt <= op[1] ? c_div_n : c_mult_n;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else begin
        if (w_mthi) r_hi <= a;
        if (w_mtlo) r_lo <= a;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// Bench for md_unit: two instances (5/10 and 1/3 cycle latencies) driven from a
// result table plus hand-written handshake sequences, checked through a scoreboard.
module tb_md_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        start;
  logic [1:0][2:0]   op;
  logic [1:0][31:0]  a, b;
  logic [1:0]        busy, stall_req;
  logic [1:0][31:0]  hi, lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .op(op[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .stall_req(stall_req[0]), .hi(hi[0]), .lo(lo[0]));

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .op(op[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .stall_req(stall_req[1]), .hi(hi[1]), .lo(lo[1]));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] hi, lo;
  } exp_t;

  vec_t        vecs[13];
  exp_t        sb[$];
  logic [31:0] m_hi[2], m_lo[2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int d, input logic [2:0] o);
    if (d == 0) return o[1] ? 10 : 5;
    return o[1] ? 3 : 1;
  endfunction

  task automatic pop_check(input int d, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty at commit", name);
    end else begin
      e = sb.pop_front();
      check({name, " dut"}, 64'(d), 64'(e.dut));
      check({name, " hi"}, 64'(hi[d]), 64'(e.hi));
      check({name, " lo"}, 64'(lo[d]), 64'(e.lo));
      m_hi[d] = e.hi;
      m_lo[d] = e.lo;
    end
  endtask

  // Called at posedge+1 of the accepting edge; returns at posedge+1 of the commit edge.
  task automatic wait_commit(input int d, input int exp_n, input string name);
    int cnt = 0;
    while (busy[d] === 1'b1 && cnt < 50) begin
      check({name, " stall"}, 64'(stall_req[d]), 64'd1);
      check({name, " hold"}, {hi[d], lo[d]}, {m_hi[d], m_lo[d]});
      @(posedge clk); #1;
      cnt++;
    end
    check({name, " busy_cycles"}, 64'(cnt), 64'(exp_n));
    pop_check(d, name);
  endtask

  task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh,
                        input logic [31:0] el, input string name);
    @(negedge clk);
    start[d] = 1'b1; op[d] = o; a[d] = va; b[d] = vb;
    #1 check({name, " stall_start"}, 64'(stall_req[d]), 64'd1);
    sb.push_back('{d, eh, el});
    @(posedge clk); #1;
    start[d] = 1'b0; op[d] = 3'd7; a[d] = '0; b[d] = '0;
    wait_commit(d, lat(d, o), name);
  endtask

  // mthi held asserted through the whole multiply, including its commit edge.
  task automatic mthi_during_busy(input int d);
    int cnt = 0;
    string name = $sformatf("mthi_busy.d%0d", d);
    @(negedge clk);
    start[d] = 1'b1; op[d] = 3'd0; a[d] = 32'hFFFFFFFD; b[d] = 32'd7;
    sb.push_back('{d, 32'hFFFFFFFF, 32'hFFFFFFEB});
    @(posedge clk); #1;
    op[d] = 3'd4; a[d] = 32'h00001234; b[d] = '0;
    while (busy[d] === 1'b1 && cnt < 50) begin
      check({name, " stall"}, 64'(stall_req[d]), 64'd1);
      @(posedge clk); #1;
      cnt++;
    end
    start[d] = 1'b0; op[d] = 3'd7; a[d] = '0;
    check({name, " busy_cycles"}, 64'(cnt), 64'(lat(d, 3'd0)));
    pop_check(d, name);
    @(posedge clk); #1;
    check({name, " hi_after"}, 64'(hi[d]), 64'(m_hi[d]));
    check({name, " busy_after"}, 64'(busy[d]), 64'd0);
  endtask

  // start arrives on the commit edge (ignored) and is held one more edge (accepted).
  task automatic commit_edge_start(input int d);
    string name = $sformatf("commit_edge.d%0d", d);
    @(negedge clk);
    start[d] = 1'b1; op[d] = 3'd2; a[d] = 32'hFFFFFFF9; b[d] = 32'd2;
    sb.push_back('{d, 32'hFFFFFFFF, 32'hFFFFFFFD});
    @(posedge clk); #1;
    start[d] = 1'b0;
    repeat (lat(d, 3'd2) - 1) @(posedge clk);
    @(negedge clk);
    start[d] = 1'b1; op[d] = 3'd1; a[d] = 32'hFFFFFFFF; b[d] = 32'd2;
    check({name, " busy_last"}, 64'(busy[d]), 64'd1);
    @(posedge clk); #1;
    check({name, " busy_commit"}, 64'(busy[d]), 64'd0);
    pop_check(d, name);
    sb.push_back('{d, 32'h00000001, 32'hFFFFFFFE});
    @(posedge clk); #1;
    start[d] = 1'b0; op[d] = 3'd7; a[d] = '0; b[d] = '0;
    check({name, " busy_accept"}, 64'(busy[d]), 64'd1);
    wait_commit(d, lat(d, 3'd1), {name, " next"});
  endtask

  task automatic single_cycle(input int d, input logic [2:0] o, input logic [31:0] v);
    string name = $sformatf("op%0d.d%0d", o, d);
    @(negedge clk);
    start[d] = 1'b1; op[d] = o; a[d] = v;
    #1 check({name, " stall"}, 64'(stall_req[d]), 64'd0);
    @(posedge clk); #1;
    start[d] = 1'b0; op[d] = 3'd7; a[d] = '0;
    if (o == 3'd4) m_hi[d] = v;
    if (o == 3'd5) m_lo[d] = v;
    check({name, " busy"}, 64'(busy[d]), 64'd0);
    check({name, " hilo"}, {hi[d], lo[d]}, {m_hi[d], m_lo[d]});
  endtask

  initial begin
    reset = 1'b0;
    start = '0;
    op    = {2{3'd7}};
    a     = '0;
    b     = '0;
    for (int d = 0; d < 2; d++) begin
      m_hi[d] = '0;
      m_lo[d] = '0;
    end
    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[7]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[12] = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset.d%0d busy", d), 64'(busy[d]), 64'd0);
      check($sformatf("reset.d%0d stall", d), 64'(stall_req[d]), 64'd0);
      check($sformatf("reset.d%0d hilo", d), {hi[d], lo[d]}, 64'd0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 13; i++)
        run_op(d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
               $sformatf("vec%0d.d%0d", i, d));

    for (int d = 0; d < 2; d++) begin
      mthi_during_busy(d);
      single_cycle(d, 3'd5, 32'h0000ABCD);
      single_cycle(d, 3'd4, 32'h00005678);
      single_cycle(d, 3'd6, 32'hDEADBEEF);
      single_cycle(d, 3'd7, 32'hCAFEF00D);
      commit_edge_start(d);
    end

    // Asynchronous reset two cycles into a multiply, then confirm no late commit.
    @(negedge clk);
    start[0] = 1'b1; op[0] = 3'd0; a[0] = 32'd5; b[0] = 32'd6;
    @(posedge clk); #1;
    start[0] = 1'b0; op[0] = 3'd7; a[0] = '0; b[0] = '0;
    repeat (2) @(posedge clk);
    #1 check("midrun busy_before", 64'(busy[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrun busy", 64'(busy[0]), 64'd0);
    check("midrun stall", 64'(stall_req[0]), 64'd0);
    check("midrun hilo.d0", {hi[0], lo[0]}, 64'd0);
    check("midrun hilo.d1", {hi[1], lo[1]}, 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset busy", 64'(busy[0]), 64'd0);
    check("post_reset hilo", {hi[0], lo[0]}, 64'd0);
    check("post_reset sb", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
